ex_mem_skid: RTL and testbench
==============================

Name: ex_mem_skid

Overview:
- Two-entry skid buffer between the EX stage (ALU, including barrel-shifter result) and the MEM stage of the RISC-V pipeline.
- Registers the EX result bundle under a valid/ready handshake and preserves order.
- Absorbs one beat of MEM back-pressure, so EX can keep a registered in_ready with no combinational ready path.
- Supplies an EX/MEM forwarding tap to the operand-forwarding logic.

Parameters:
- XLEN, 32, datapath width of result, store data and pc
- REGW, 5, register-index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all buffered beats (branch mispredict / trap)
- in_valid  in  1  EX beat present
- in_ready  out  1  buffer can accept; registered
- in_result  in  XLEN  ALU/shift result, or memory address for load/store
- in_store_data  in  XLEN  rs2 value for stores
- in_pc  in  XLEN  instruction pc
- in_rd  in  REGW  destination register
- in_wen  in  1  register write enable
- in_mem_rd  in  1  load
- in_mem_wr  in  1  store
- in_funct3  in  3  memory access size/sign
- out_valid  out  1  MEM beat present
- out_ready  in  1  MEM accepts
- out_result, out_store_data, out_pc, out_rd, out_wen, out_mem_rd, out_mem_wr, out_funct3  out  as inputs  head-entry bundle
- occ  out  2  entries held (0..2)
- fwd_valid  out  1  head entry will write a register
- fwd_rd  out  REGW  forwarded destination
- fwd_data  out  XLEN  forwarded value (head out_result)
- fwd_is_load  out  1  head is a load; value not yet available, consumer must stall

Behaviour:
- Storage: main entry (drives out_*) and skid entry. Each entry has a valid bit.
- Handshake:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - out_valid = main_valid
  - in_ready = !skid_valid, as a flop
  - out_* must hold stable while out_valid & !out_ready.
- Latency: a beat pushed at edge N is visible on out_* after edge N; one cycle minimum.
- Per-edge transitions (flush=0):
  - occ 0, push: main <= in.
  - occ 1, push & pop: main <= in.
  - occ 1, push & !pop: skid <= in.
  - occ 1, pop & !push: main_valid <= 0.
  - occ 2, pop: main <= skid; skid_valid <= 0. No push is possible at occ 2.
  - occ 2, !pop: hold.
- Order is strict FIFO; no beat is duplicated or lost.
- x0 rule: the stored wen is in_wen & (in_rd != 0). out_wen and fwd_valid are never 1 for rd=0.
- flush:
  - Next edge: main_valid = skid_valid = 0; in_ready = 1.
  - A push in the same cycle is discarded.
  - A pop in the same cycle still completes: MEM sees it this cycle.
  - flush has priority over every other transition.
- Reset (asserted asynchronously, released synchronously by the system):
  - main_valid = skid_valid = 0; all stored data = 0.
  - out_* = 0, out_valid = 0, occ = 0, fwd_* = 0.
  - in_ready = 1.
  - Reset mid-operation drops all beats; there is no recovery.
- occ = main_valid + skid_valid, registered consistently with the valid bits.
- Data-path flops may be non-reset only if the outputs are gated by valid. The default is reset-to-zero.

Optional Feature:
- Macro: EXMEM_FWD_EN.
- Defined:
  - fwd_valid = main_valid & out_wen
  - fwd_rd = out_rd
  - fwd_data = out_result
  - fwd_is_load = main_valid & out_mem_rd
- Undefined:
  - All fwd_* ports are present but tied to 0, keeping the interface stable.
  - The forwarding unit falls back to the MEM/WB source or a stall.
- Handshake behaviour is identical in both builds.

Test Plan:
- Reset: rst_n=0 mid-stream with occ=2 -> immediately out_valid=0, occ=0, out_result=0; after release in_ready=1.
- Streaming: out_ready=1, in_valid=1 every cycle with results 0x1,0x2,0x3 -> out_result 0x1,0x2,0x3 on consecutive cycles, one cycle after each push; occ stays 1; in_ready stays 1.
- Back-pressure: push 0xA then 0xB with out_ready=0 -> occ=2, in_ready=0, out_result holds 0xA; raise out_ready -> 0xA, then 0xB, then out_valid=0, in_ready=1.
- Flush: occ=2 with a push asserted in the same cycle as flush -> next cycle occ=0, out_valid=0; the pushed beat never appears.
- x0 suppression: push rd=0, wen=1, result 0xDEADBEEF -> out_wen=0, fwd_valid=0; push rd=5 -> out_wen=1, fwd_rd=5 (EXMEM_FWD_EN defined).
- Forward load: push load with rd=7, EXMEM_FWD_EN defined -> fwd_is_load=1, fwd_rd=7; same stimulus with the macro undefined -> all fwd_* = 0.

Source files
------------

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry EX/MEM skid buffer with registered in_ready.
// Optional forwarding tap enabled by defining EXMEM_FWD_EN.
module ex_mem_skid #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [XLEN-1:0] in_pc,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_wen,
    input  logic            in_mem_rd,
    input  logic            in_mem_wr,
    input  logic [2:0]      in_funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc,
    output logic [REGW-1:0] out_rd,
    output logic            out_wen,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic [2:0]      out_funct3,
    output logic [1:0]      occ,
    output logic            fwd_valid,
    output logic [REGW-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_is_load
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rd;
        logic            wen;
        logic            mem_rd;
        logic            mem_wr;
        logic [2:0]      funct3;
    } entry_t;

    entry_t     main_q;
    entry_t     main_d;
    entry_t     skid_q;
    entry_t     skid_d;
    entry_t     in_entry;
    logic       main_valid;
    logic       main_valid_d;
    logic       skid_valid;
    logic       skid_valid_d;
    logic       ready_q;
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic       push;
    logic       pop;

    assign push = in_valid & ready_q;
    assign pop  = main_valid & out_ready;

    // Pack the incoming beat; writes to x0 are dropped at capture time.
    always_comb begin
        in_entry            = '0;
        in_entry.result     = in_result;
        in_entry.store_data = in_store_data;
        in_entry.pc         = in_pc;
        in_entry.rd         = in_rd;
        in_entry.wen        = in_wen & (in_rd != '0);
        in_entry.mem_rd     = in_mem_rd;
        in_entry.mem_wr     = in_mem_wr;
        in_entry.funct3     = in_funct3;
    end

    // Next-state for both entries; flush wins over every transition.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid) begin
            if (push) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end
        end else if (!skid_valid) begin
            if (push && pop) begin
                main_d = in_entry;
            end else if (push) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end
        end else if (pop) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end
        occ_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    // State registers; in_ready and occ are registered alongside the valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            ready_q    <= !skid_valid_d;
            occ_q      <= occ_d;
        end
    end

    assign in_ready       = ready_q;
    assign occ            = occ_q;
    assign out_valid      = main_valid;
    assign out_result     = main_q.result;
    assign out_store_data = main_q.store_data;
    assign out_pc         = main_q.pc;
    assign out_rd         = main_q.rd;
    assign out_wen        = main_q.wen;
    assign out_mem_rd     = main_q.mem_rd;
    assign out_mem_wr     = main_q.mem_wr;
    assign out_funct3     = main_q.funct3;

`ifdef EXMEM_FWD_EN
    assign fwd_valid   = main_valid & main_q.wen;
    assign fwd_rd      = main_q.rd;
    assign fwd_data    = main_q.result;
    assign fwd_is_load = main_valid & main_q.mem_rd;
`else
    assign fwd_valid   = 1'b0;
    assign fwd_rd      = '0;
    assign fwd_data    = '0;
    assign fwd_is_load = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: directed checks of the EX/MEM skid buffer.
// Forwarding expectations follow EXMEM_FWD_EN.
module tb_ex_mem_skid;

    localparam int XLEN = 32;
    localparam int REGW = 5;

`ifdef EXMEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_result;
    logic [XLEN-1:0] in_store_data;
    logic [XLEN-1:0] in_pc;
    logic [REGW-1:0] in_rd;
    logic            in_wen;
    logic            in_mem_rd;
    logic            in_mem_wr;
    logic [2:0]      in_funct3;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_store_data;
    logic [XLEN-1:0] out_pc;
    logic [REGW-1:0] out_rd;
    logic            out_wen;
    logic            out_mem_rd;
    logic            out_mem_wr;
    logic [2:0]      out_funct3;
    logic [1:0]      occ;
    logic            fwd_valid;
    logic [REGW-1:0] fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            fwd_is_load;

    int passed = 0;
    int total  = 0;

    ex_mem_skid #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_store_data(in_store_data),
        .in_pc(in_pc), .in_rd(in_rd), .in_wen(in_wen),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
        .in_funct3(in_funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_pc(out_pc), .out_rd(out_rd), .out_wen(out_wen),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_funct3(out_funct3), .occ(occ),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .fwd_is_load(fwd_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] r,
                         input logic [REGW-1:0] rd, input logic wen,
                         input logic ld);
        in_valid      = v;
        in_result     = r;
        in_store_data = r ^ 32'hFFFF_0000;
        in_pc         = r + 32'h1000;
        in_rd         = rd;
        in_wen        = wen;
        in_mem_rd     = ld;
        in_mem_wr     = 1'b0;
        in_funct3     = 3'b010;
    endtask

    task automatic test_reset();
        total++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1)
            $display("FAIL reset_ctrl: valid=%b occ=%0d rdy=%b want 0 0 1",
                     out_valid, occ, in_ready);
        else passed++;
        total++;
        if (out_result !== '0 || out_pc !== '0 || fwd_valid !== 1'b0)
            $display("FAIL reset_data: res=%h pc=%h fv=%b want 0 0 0",
                     out_result, out_pc, fwd_valid);
        else passed++;
    endtask

    task automatic test_streaming();
        logic [XLEN-1:0] exp;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            exp = XLEN'(i);
            drive(1'b1, exp, 5'd3, 1'b1, 1'b0);
            step();
            total++;
            if (out_valid !== 1'b1 || out_result !== exp)
                $display("FAIL stream_out%0d: valid=%b res=%h want 1 %h",
                         i, out_valid, out_result, exp);
            else passed++;
            total++;
            if (occ !== 2'd1 || in_ready !== 1'b1)
                $display("FAIL stream_occ%0d: occ=%0d rdy=%b want 1 1",
                         i, occ, in_ready);
            else passed++;
        end
        total++;
        if (out_pc !== 32'h1003 || out_store_data !== 32'hFFFF_0003)
            $display("FAIL stream_side: pc=%h sd=%h want 1003 ffff0003",
                     out_pc, out_store_data);
        else passed++;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        total++;
        if (out_valid !== 1'b0 || occ !== 2'd0)
            $display("FAIL stream_drain: valid=%b occ=%0d want 0 0",
                     out_valid, occ);
        else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd1, 1'b1, 1'b0);
        step();
        total++;
        if (occ !== 2'd1 || in_ready !== 1'b1 || out_result !== 32'hA)
            $display("FAIL bp_first: occ=%0d rdy=%b res=%h want 1 1 a",
                     occ, in_ready, out_result);
        else passed++;
        drive(1'b1, 32'hB, 5'd2, 1'b1, 1'b0);
        step();
        total++;
        if (occ !== 2'd2 || in_ready !== 1'b0 || out_result !== 32'hA)
            $display("FAIL bp_full: occ=%0d rdy=%b res=%h want 2 0 a",
                     occ, in_ready, out_result);
        else passed++;
        drive(1'b1, 32'hC, 5'd3, 1'b1, 1'b0);
        step();
        total++;
        if (occ !== 2'd2 || out_result !== 32'hA || out_rd !== 5'd1)
            $display("FAIL bp_hold: occ=%0d res=%h rd=%0d want 2 a 1",
                     occ, out_result, out_rd);
        else passed++;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_result !== 32'hA)
            $display("FAIL bp_pop_a: valid=%b res=%h want 1 a",
                     out_valid, out_result);
        else passed++;
        step();
        total++;
        if (out_result !== 32'hB || occ !== 2'd1 || in_ready !== 1'b1)
            $display("FAIL bp_pop_b: res=%h occ=%0d rdy=%b want b 1 1",
                     out_result, occ, in_ready);
        else passed++;
        step();
        total++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1)
            $display("FAIL bp_empty: valid=%b occ=%0d rdy=%b want 0 0 1",
                     out_valid, occ, in_ready);
        else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd4, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h22, 5'd4, 1'b1, 1'b0);
        step();
        total++;
        if (occ !== 2'd2)
            $display("FAIL flush_fill: occ=%0d want 2", occ);
        else passed++;
        flush = 1'b1;
        drive(1'b1, 32'h33, 5'd4, 1'b1, 1'b0);
        step();
        flush = 1'b0;
        total++;
        if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_kill: occ=%0d valid=%b rdy=%b want 0 0 1",
                     occ, out_valid, in_ready);
        else passed++;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || occ !== 2'd0)
            $display("FAIL flush_nopush: valid=%b occ=%0d want 0 0",
                     out_valid, occ);
        else passed++;
    endtask

    task automatic test_x0();
        out_ready = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0);
        step();
        total++;
        if (out_wen !== 1'b0 || fwd_valid !== 1'b0 ||
            out_result !== 32'hDEADBEEF)
            $display("FAIL x0_drop: wen=%b fv=%b res=%h want 0 0 deadbeef",
                     out_wen, fwd_valid, out_result);
        else passed++;
        drive(1'b1, 32'h55, 5'd5, 1'b1, 1'b0);
        step();
        total++;
        if (out_wen !== 1'b1 || out_rd !== 5'd5)
            $display("FAIL x5_wen: wen=%b rd=%0d want 1 5", out_wen, out_rd);
        else passed++;
        total++;
        if (fwd_valid !== FWD || fwd_rd !== (FWD ? 5'd5 : 5'd0) ||
            fwd_data !== (FWD ? 32'h55 : 32'h0))
            $display("FAIL x5_fwd: fv=%b rd=%0d d=%h fwd_en=%b",
                     fwd_valid, fwd_rd, fwd_data, FWD);
        else passed++;
    endtask

    task automatic test_fwd_load();
        out_ready = 1'b1;
        drive(1'b1, 32'h400, 5'd7, 1'b1, 1'b1);
        step();
        total++;
        if (out_mem_rd !== 1'b1 || out_rd !== 5'd7)
            $display("FAIL ld_out: mrd=%b rd=%0d want 1 7", out_mem_rd, out_rd);
        else passed++;
        total++;
        if (fwd_is_load !== FWD || fwd_rd !== (FWD ? 5'd7 : 5'd0) ||
            fwd_valid !== FWD)
            $display("FAIL ld_fwd: ld=%b rd=%0d fv=%b fwd_en=%b",
                     fwd_is_load, fwd_rd, fwd_valid, FWD);
        else passed++;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        total++;
        if (fwd_is_load !== 1'b0 || fwd_valid !== 1'b0)
            $display("FAIL ld_clear: ld=%b fv=%b want 0 0",
                     fwd_is_load, fwd_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 5'd6, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h88, 5'd6, 1'b1, 1'b0);
        step();
        total++;
        if (occ !== 2'd2)
            $display("FAIL rst_fill: occ=%0d want 2", occ);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || out_result !== '0)
            $display("FAIL rst_async: valid=%b occ=%0d res=%h want 0 0 0",
                     out_valid, occ, out_result);
        else passed++;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_release: rdy=%b valid=%b want 1 0",
                     in_ready, out_valid);
        else passed++;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_streaming();
        test_backpressure();
        test_flush();
        test_x0();
        test_fwd_load();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
